// File: rtl/nv_nvdla_cacc_pingpong_ctrl_pkg.sv
// Shared definitions for the CACC ping-pong register-group controller.
// Holds the local register offsets, the per-group status encoding reported
// through S_STATUS, and the launch FSM state encoding.
package nv_nvdla_cacc_pingpong_ctrl_pkg;

    localparam int OFFSET_W = 12;
    localparam int DATA_W   = 32;

    localparam logic [11:0] STATUS_OFS    = 12'h000;
    localparam logic [11:0] POINTER_OFS   = 12'h004;
    localparam logic [11:0] OP_ENABLE_OFS = 12'h008;

    // Per-group status as reported in S_STATUS
    typedef enum logic [1:0] {
        GRP_IDLE    = 2'd0,
        GRP_RUNNING = 2'd1,
        GRP_PENDING = 2'd2
    } grp_status_e;

    // Datapath launch sequencer
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } cacc_state_e;

endpackage

// File: rtl/nv_nvdla_cacc_pingpong_grp_state.sv
// One register group's op_en flag and its status encoding.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   set_i       - accepted op_en=1 write to this group
//   clr_i       - datapath completed a layer on this group
//   active_i    - this group is the consumer and the launch FSM is busy
//   op_en_o     - registered op_en
//   status_o    - IDLE / RUNNING / PENDING
module nv_nvdla_cacc_pingpong_grp_state
    import nv_nvdla_cacc_pingpong_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_i,
    input  logic        clr_i,
    input  logic        active_i,
    output logic        op_en_o,
    output grp_status_e status_o
);

    logic op_en_q;
    logic op_en_d;

    // Set and clear never coincide on one group: a write to a group whose
    // op_en is high is blocked, and only a group with op_en high completes.
    assign op_en_d = (op_en_q | set_i) & ~clr_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_en_q <= 1'b0;
        end else begin
            op_en_q <= op_en_d;
        end
    end

    always_comb begin
        status_o = GRP_IDLE;
        if (op_en_q) begin
            status_o = active_i ? GRP_RUNNING : GRP_PENDING;
        end
    end

    assign op_en_o = op_en_q;

endmodule

// File: rtl/nv_nvdla_cacc_pingpong_ctrl.sv
// CACC ping-pong controller: routes CSB accesses to the producer register
// group, tracks per-group op_en/status, launches the datapath on the
// consumer group and retires it on completion.
// Ports:
//   nvdla_core_clk/rstn         - clock, asynchronous active-low reset
//   reg_offset/wr_en/wr_data    - CSB request; reg_rd_data is combinational
//   d_reg_wr_en, d_rd_data0/1   - per-group register-file write enable / read data
//   d_op_en                     - per-group op_en
//   dp_start/group/busy/done    - datapath handshake
//   done_intr                   - per-group completion interrupt pulse
//   wr_blocked, done_err        - error pulses (dropped write, stray dp_done)
module nv_nvdla_cacc_pingpong_ctrl
    import nv_nvdla_cacc_pingpong_ctrl_pkg::*;
#(
    parameter int                   OFFSET_W    = 12,
    parameter int                   DATA_W      = 32,
    parameter logic [OFFSET_W-1:0]  STATUS_OFS  = 12'h000,
    parameter logic [OFFSET_W-1:0]  POINTER_OFS = 12'h004
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic [OFFSET_W-1:0] reg_offset,
    input  logic                reg_wr_en,
    input  logic [DATA_W-1:0]   reg_wr_data,
    output logic [DATA_W-1:0]   reg_rd_data,
    output logic [1:0]          d_reg_wr_en,
    input  logic [DATA_W-1:0]   d_rd_data0,
    input  logic [DATA_W-1:0]   d_rd_data1,
    output logic [1:0]          d_op_en,
    output logic                dp_start,
    output logic                dp_group,
    output logic                dp_busy,
    input  logic                dp_done,
    output logic [1:0]          done_intr,
    output logic                wr_blocked,
    output logic                done_err
);

    cacc_state_e state_q, state_d;
    logic        producer_q, producer_d;
    logic        consumer_q, consumer_d;
    logic [1:0]  done_intr_q;
    logic        wr_blocked_q;
    logic        done_err_q;

    logic        is_status, is_pointer, is_group, is_op_en_ofs;
    logic        grp_wr_ok, done_fire;
    logic [1:0]  op_en, grp_set, grp_clr, grp_active;
    grp_status_e grp_status [2];
    logic        unused_wr_bits;

    assign unused_wr_bits = ^reg_wr_data[DATA_W-1:1];

    // Address decode
    assign is_status    = (reg_offset == STATUS_OFS);
    assign is_pointer   = (reg_offset == POINTER_OFS);
    assign is_group     = ~is_status & ~is_pointer;
    assign is_op_en_ofs = (reg_offset == OFFSET_W'(OP_ENABLE_OFS));

    // A group write only lands while the producer group is not armed
    assign grp_wr_ok = reg_wr_en & is_group & ~op_en[producer_q];
    assign done_fire = dp_done & (state_q == ST_RUN);

    for (genvar gi = 0; gi < 2; gi++) begin : g_grp
        assign d_reg_wr_en[gi] = grp_wr_ok & (producer_q == 1'(gi));
        assign grp_set[gi]     = d_reg_wr_en[gi] & is_op_en_ofs & reg_wr_data[0];
        assign grp_clr[gi]     = done_fire & (consumer_q == 1'(gi));
        assign grp_active[gi]  = (consumer_q == 1'(gi)) & (state_q != ST_IDLE);

        nv_nvdla_cacc_pingpong_grp_state u_grp_state (
            .clk      (nvdla_core_clk),
            .rst_n    (nvdla_core_rstn),
            .set_i    (grp_set[gi]),
            .clr_i    (grp_clr[gi]),
            .active_i (grp_active[gi]),
            .op_en_o  (op_en[gi]),
            .status_o (grp_status[gi])
        );
    end

    // Launch sequencer and pointers
    always_comb begin
        state_d    = state_q;
        producer_d = producer_q;
        consumer_d = consumer_q;
        if (reg_wr_en && is_pointer) begin
            producer_d = reg_wr_data[0];
        end
        case (state_q)
            ST_IDLE:  if (op_en[consumer_q]) state_d = ST_START;
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (dp_done) begin
                    state_d    = ST_IDLE;
                    consumer_d = ~consumer_q;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q      <= ST_IDLE;
            producer_q   <= 1'b0;
            consumer_q   <= 1'b0;
            done_intr_q  <= 2'b00;
            wr_blocked_q <= 1'b0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            producer_q   <= producer_d;
            consumer_q   <= consumer_d;
            done_intr_q  <= grp_clr;
            wr_blocked_q <= reg_wr_en & is_group & op_en[producer_q];
            done_err_q   <= dp_done & (state_q != ST_RUN);
        end
    end

    // CSB read mux
    always_comb begin
        logic [31:0] local_rd;
        local_rd = {14'b0, grp_status[1], 14'b0, grp_status[0]};
        if (is_pointer) begin
            local_rd = {15'b0, consumer_q, 15'b0, producer_q};
        end
        if (is_group) begin
            reg_rd_data = producer_q ? d_rd_data1 : d_rd_data0;
        end else begin
            reg_rd_data = DATA_W'(local_rd);
        end
    end

    assign d_op_en    = op_en;
    assign dp_start   = (state_q == ST_START);
    assign dp_busy    = (state_q != ST_IDLE);
    assign dp_group   = consumer_q;
    assign done_intr  = done_intr_q;
    assign wr_blocked = wr_blocked_q;
    assign done_err   = done_err_q;

endmodule

// File: tb/tb_nv_nvdla_cacc_pingpong_ctrl.sv
module tb_nv_nvdla_cacc_pingpong_ctrl;

    localparam logic [11:0] S_STATUS  = 12'h000;
    localparam logic [11:0] S_POINTER = 12'h004;
    localparam logic [11:0] S_OPEN    = 12'h008;
    localparam logic [11:0] S_OTHER   = 12'h010;

    logic        clk = 1'b0;
    logic        rstn;
    logic [11:0] reg_offset;
    logic        reg_wr_en;
    logic [31:0] reg_wr_data;
    logic [31:0] reg_rd_data;
    logic [1:0]  d_reg_wr_en;
    logic [31:0] d_rd_data0, d_rd_data1;
    logic [1:0]  d_op_en;
    logic        dp_start, dp_group, dp_busy, dp_done;
    logic [1:0]  done_intr;
    logic        wr_blocked, done_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pointers, armed groups, and whether a layer is in
    // flight ("fresh" marks the launch cycle of that layer).
    bit       m_prod, m_cons, m_busy, m_fresh;
    bit [1:0] m_op, m_intr;
    bit       m_blk, m_err;

    always #5 clk = ~clk;

    nv_nvdla_cacc_pingpong_ctrl dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .reg_offset      (reg_offset),
        .reg_wr_en       (reg_wr_en),
        .reg_wr_data     (reg_wr_data),
        .reg_rd_data     (reg_rd_data),
        .d_reg_wr_en     (d_reg_wr_en),
        .d_rd_data0      (d_rd_data0),
        .d_rd_data1      (d_rd_data1),
        .d_op_en         (d_op_en),
        .dp_start        (dp_start),
        .dp_group        (dp_group),
        .dp_busy         (dp_busy),
        .dp_done         (dp_done),
        .done_intr       (done_intr),
        .wr_blocked      (wr_blocked),
        .done_err        (done_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_status(input bit g);
        if (!m_op[g])                 return 2'd0;
        else if (m_busy && m_cons == g) return 2'd1;
        else                          return 2'd2;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] off);
        if (off == S_STATUS)       return {14'b0, m_status(1'b1), 14'b0, m_status(1'b0)};
        else if (off == S_POINTER) return {15'b0, m_cons, 15'b0, m_prod};
        else                       return m_prod ? d_rd_data1 : d_rd_data0;
    endfunction

    task automatic chk_regs();
        chk("d_op_en",    {30'b0, d_op_en},   {30'b0, m_op});
        chk("dp_start",   {31'b0, dp_start},  {31'b0, (m_busy && m_fresh)});
        chk("dp_busy",    {31'b0, dp_busy},   {31'b0, m_busy});
        chk("dp_group",   {31'b0, dp_group},  {31'b0, m_cons});
        chk("done_intr",  {30'b0, done_intr}, {30'b0, m_intr});
        chk("wr_blocked", {31'b0, wr_blocked},{31'b0, m_blk});
        chk("done_err",   {31'b0, done_err},  {31'b0, m_err});
    endtask

    // One clock of CSB/datapath activity, checked against the model
    task automatic step(input bit wr, input logic [11:0] off, input logic [31:0] data, input bit done);
        bit       grp;
        bit [1:0] n_op, n_intr;
        bit       n_prod, n_cons, n_busy, n_fresh, n_err;
        logic [1:0] exp_we;
        @(negedge clk);
        reg_wr_en   = wr;
        reg_offset  = off;
        reg_wr_data = data;
        dp_done     = done;
        d_rd_data0  = $urandom;
        d_rd_data1  = $urandom;
        #1;
        grp    = (off != S_STATUS) && (off != S_POINTER);
        exp_we = 2'b00;
        if (wr && grp && !m_op[m_prod]) exp_we[m_prod] = 1'b1;
        chk("d_reg_wr_en", {30'b0, d_reg_wr_en}, {30'b0, exp_we});
        chk("reg_rd_data", reg_rd_data, m_read(off));

        @(posedge clk);
        #1;
        n_op = m_op; n_prod = m_prod; n_cons = m_cons; n_busy = m_busy;
        n_fresh = 1'b0; n_intr = 2'b00; n_err = 1'b0;
        m_blk = wr && grp && m_op[m_prod];
        if (wr && off == S_POINTER) n_prod = data[0];
        if (wr && grp && !m_op[m_prod] && off == S_OPEN && data[0]) n_op[m_prod] = 1'b1;
        if (done && m_busy && !m_fresh) begin
            n_op[m_cons]   = 1'b0;
            n_intr[m_cons] = 1'b1;
            n_cons         = ~m_cons;
            n_busy         = 1'b0;
        end else begin
            if (done) n_err = 1'b1;
            if (!m_busy && m_op[m_cons]) begin
                n_busy  = 1'b1;
                n_fresh = 1'b1;
            end
        end
        m_op = n_op; m_prod = n_prod; m_cons = n_cons; m_busy = n_busy;
        m_fresh = n_fresh; m_intr = n_intr; m_err = n_err;
        chk_regs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reg_wr_en  = 1'b0;
        dp_done    = 1'b0;
        reg_offset = S_POINTER;
        rstn       = 1'b0;
        #1;
        m_op = 2'b00; m_prod = 1'b0; m_cons = 1'b0; m_busy = 1'b0;
        m_fresh = 1'b0; m_intr = 2'b00; m_blk = 1'b0; m_err = 1'b0;
        chk_regs();
        chk("rst_pointer", reg_rd_data, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [31:0] rv;
        logic [11:0] ro;
        int          sel;
        rstn = 1'b0; reg_wr_en = 1'b0; reg_offset = 12'h0; reg_wr_data = 32'h0;
        dp_done = 1'b0; d_rd_data0 = 32'h0; d_rd_data1 = 32'h0;
        do_reset();

        // Arm group 0 and launch it
        step(1, S_OPEN, 32'h1, 0);
        chk("plan_op_en0", {30'b0, d_op_en}, 32'h1);
        step(0, S_STATUS, 32'h0, 0);
        chk("plan_start0", {31'b0, dp_start}, 32'h1);
        step(0, S_STATUS, 32'h0, 0);
        chk("plan_status_run", reg_rd_data, 32'h0000_0001);

        // Program and arm group 1 while group 0 runs
        step(1, S_POINTER, 32'hFFFF_FFFF, 0);
        step(1, S_OTHER, 32'h55, 0);
        chk("plan_wr_en_g1", {30'b0, d_reg_wr_en}, 32'h2);
        step(1, S_OPEN, 32'h1, 0);
        step(0, S_STATUS, 32'h0, 0);
        chk("plan_status_both", reg_rd_data, 32'h0002_0001);
        step(0, S_STATUS, 32'h0, 1);
        chk("plan_intr_g0", {30'b0, done_intr}, 32'h1);
        step(0, S_POINTER, 32'h0, 0);
        chk("plan_start_g1", {31'b0, dp_start}, 32'h1);
        chk("plan_pointer", reg_rd_data, 32'h0001_0001);
        step(0, S_STATUS, 32'h0, 0);

        // Arm group 0 in the same cycle group 1 completes
        step(1, S_POINTER, 32'h0, 0);
        step(1, S_OPEN, 32'h1, 1);
        chk("plan_simul_op_en", {30'b0, d_op_en}, 32'h1);
        chk("plan_simul_intr", {30'b0, done_intr}, 32'h2);
        step(0, S_STATUS, 32'h0, 0);
        chk("plan_simul_start", {31'b0, dp_start}, 32'h1);

        // Write to the armed producer group is dropped
        step(1, S_OTHER, 32'hA5A5_A5A5, 0);
        chk("plan_blocked", {31'b0, wr_blocked}, 32'h1);

        // Complete group 0, then a stray dp_done in IDLE
        step(0, S_STATUS, 32'h0, 1);
        step(0, S_STATUS, 32'h0, 1);
        chk("plan_done_err", {31'b0, done_err}, 32'h1);
        chk("plan_no_intr", {30'b0, done_intr}, 32'h0);

        // Reset mid-layer, then a dp_done after release
        step(1, S_POINTER, 32'h1, 0);
        step(1, S_OPEN, 32'h1, 0);
        step(0, S_STATUS, 32'h0, 0);
        step(0, S_STATUS, 32'h0, 0);
        do_reset();
        step(0, S_POINTER, 32'h0, 1);
        chk("plan_err_after_rst", {31'b0, done_err}, 32'h1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 11);
            rv  = $urandom;
            ro  = 12'($urandom);
            case (sel)
                0:       step(1, S_POINTER, rv, 0);
                1, 2:    step(1, S_OPEN, rv, ($urandom_range(0, 5) == 0));
                3:       step(1, S_OTHER, rv, ($urandom_range(0, 3) == 0));
                4:       step(1, ro, rv, 0);
                5:       step(1, S_STATUS, rv, 0);
                6:       step(0, S_POINTER, rv, 0);
                7:       step(0, ro, rv, ($urandom_range(0, 7) == 0));
                8, 9:    step(0, S_STATUS, rv, m_busy || ($urandom_range(0, 7) == 0));
                10:      step(0, S_OTHER, rv, 0);
                default: begin
                    if ($urandom_range(0, 9) == 0) do_reset();
                    else step(0, S_STATUS, rv, 0);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_cacc_pingpong_ctrl.md
Name: nv_nvdla_cacc_pingpong_ctrl

Overview:
- Sequences the two ping-pong CACC configuration register groups (group 0 and group 1).
- Routes CSB writes and reads to the producer group, tracks per-group op_en and status, and launches the CACC datapath on the consumer group.
- On datapath completion, retires the consumer group, flips the consumer pointer and raises the per-group done interrupt.
- Sits between the CSB register decode and the two per-group CACC register files.

Parameters:
- OFFSET_W, 12, register offset width.
- DATA_W, 32, register data width.
- STATUS_OFS, 12'h000, offset of the single S_STATUS register.
- POINTER_OFS, 12'h004, offset of the single S_POINTER register.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  asynchronous active-low reset.
- reg_offset  in  OFFSET_W  CSB register offset.
- reg_wr_en  in  1  CSB write strobe, one cycle.
- reg_wr_data  in  DATA_W  CSB write data.
- reg_rd_data  out  DATA_W  CSB read data, combinational.
- d_reg_wr_en  out  2  per-group write enable to the group register files.
- d_rd_data0  in  DATA_W  group 0 register-file read data.
- d_rd_data1  in  DATA_W  group 1 register-file read data.
- d_op_en  out  2  per-group op_en, fed back to the group register-file read path.
- dp_start  out  1  one-cycle launch pulse to the datapath.
- dp_group  out  1  group the datapath uses (consumer pointer).
- dp_busy  out  1  datapath layer in progress.
- dp_done  in  1  one-cycle layer-complete pulse from the datapath.
- done_intr  out  2  one-cycle per-group done interrupt.
- wr_blocked  out  1  one-cycle pulse when a write to a busy group is dropped.
- done_err  out  1  one-cycle pulse when dp_done arrives outside the RUN state.

Behaviour:
- Reset values (asynchronous, active-low): producer=0, consumer=0, op_en=2'b00, state=IDLE. All registered outputs are 0: dp_start, dp_busy, done_intr, wr_blocked, done_err.
- Decode: an offset of STATUS_OFS or POINTER_OFS is local. Any other offset is a group offset.
- S_POINTER write: producer <= wr_data[0]. Bits [31:1] are ignored.
- S_POINTER read: {15'b0, consumer, 15'b0, producer}.
- S_STATUS is read-only; writes are ignored. Read value: {14'b0, st1, 14'b0, st0}.
  - stg = 0 idle: op_en[g]=0.
  - stg = 1 running: op_en[g]=1, g==consumer, state!=IDLE.
  - stg = 2 pending: op_en[g]=1 otherwise.
- Group write: d_reg_wr_en[producer] = reg_wr_en & group offset & ~op_en[producer], combinational, same cycle. If op_en[producer]=1 the write is dropped and wr_blocked pulses the next cycle.
- Group read: reg_rd_data = producer ? d_rd_data1 : d_rd_data0.
- op_en set: a group write to offset 12'h008 with wr_data[0]=1 that is not blocked sets op_en[producer] the next cycle. Writing 0 has no effect. op_en is cleared only by completion.
- FSM (states IDLE, START, RUN):
  - IDLE -> START when op_en[consumer]=1.
  - START -> RUN unconditionally. dp_start=1 only in START.
  - RUN -> IDLE on dp_done.
  - dp_busy = (state != IDLE).
  - dp_group = consumer, stable from START through RUN.
- Completion, dp_done in cycle N while in RUN:
  - At N+1: op_en[consumer]=0, consumer toggled, done_intr[old consumer]=1 for exactly one cycle, state=IDLE.
  - At N+2: if op_en of the new consumer is already 1, dp_start is high.
- dp_done while in IDLE or START: ignored, done_err pulses at N+1, no state change.
- Simultaneous op_en set and completion on different groups: both take effect in the same cycle.
- Same group: this cannot occur, because the write is blocked while op_en=1.
- Producer pointer write and group write in the same cycle cannot occur, since there is a single CSB port.
- Reset asserted mid-layer: everything returns to reset values immediately. A dp_done after reset release lands in IDLE and raises done_err.
- Latency:
  - op_en write to dp_start: 2 cycles (op_en set at +1, START at +2).
  - dp_done to done_intr: 1 cycle.

Decomposition:
- Shared package holds:
  - STATUS_OFS, POINTER_OFS, OP_ENABLE_OFS (12'h008).
  - Group status encodings: IDLE=2'd0, RUNNING=2'd1, PENDING=2'd2.
  - FSM state encoding.
- One natural sub-module: nv_nvdla_cacc_pingpong_grp_state, instantiated twice. It holds a single group's op_en flop, set/clear logic and status encoding.
- The top level holds the pointers, FSM, write/read routing and error pulses.

Test Plan:
- Reset, then write 12'h008=1 with producer=0 -> d_op_en=2'b01 at +1; dp_start at +2 with dp_group=0; S_STATUS reads 0x00000001 during RUN.
- Write S_POINTER=1, write 12'h010=0x55 -> d_reg_wr_en=2'b10 for one cycle. Then set group-1 op_en while group 0 runs -> S_STATUS reads 0x00020001. Pulse dp_done -> done_intr=2'b01 at +1, dp_start for group 1 at +2, S_POINTER reads 0x00010001.
- With group-0 op_en=1 and producer=0, write 12'h010 -> d_reg_wr_en stays 0 and wr_blocked pulses at +1.
- Pulse dp_done in IDLE -> done_err pulses, consumer stays 0, done_intr stays 0.
- Group 1 running, group 0 idle: write op_en=1 to group 0 in the same cycle as dp_done -> at +1 d_op_en=2'b01, consumer=0, done_intr=2'b10; dp_start with dp_group=0 at +2.
- Deassert nvdla_core_rstn during RUN -> all outputs 0 and S_POINTER reads 0 immediately. A subsequent dp_done raises done_err.
